// File: rtl/npu_pkg.sv
// Definitions shared between the DPE and its downstream accumulator:
// the DPE result width, the accumulator FSM encoding and a saturating adder.
package npu_pkg;

  localparam int DPE_ODATAW = 24;
  localparam int SAT_W      = 64;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Operands must already lie within the signed range of 'width' bits (width < SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    logic signed [SAT_W-1:0] r;
    one = (SAT_W+1)'(1);
    s   = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi  = (one <<< (width - 1)) - one;
    lo  = -(one <<< (width - 1));
    if (s > hi)
      r = hi[SAT_W-1:0];
    else if (s < lo)
      r = lo[SAT_W-1:0];
    else
      r = s[SAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/dpe_accumulator_if.sv
// Result stream between the DPE, the accumulator and its downstream consumer.
interface dpe_accumulator_if #(
  parameter int BATCH  = 1,
  parameter int IDATAW = 24,
  parameter int ODATAW = 32,
  parameter int TILEW  = 5
);
  logic [BATCH-1:0][IDATAW-1:0] i_data;
  logic                         i_valid;
  logic [TILEW-1:0]             i_num_tiles;
  logic [BATCH-1:0][ODATAW-1:0] o_data;
  logic                         o_valid;
  logic                         i_ready;
  logic                         o_almost_full;
  logic                         o_overflow;

  modport master (
    output i_data, i_valid, i_num_tiles, i_ready,
    input  o_data, o_valid, o_almost_full, o_overflow
  );

  modport slave (
    input  i_data, i_valid, i_num_tiles, i_ready,
    output o_data, o_valid, o_almost_full, o_overflow
  );
endinterface

// File: rtl/dpe_accumulator_result_fifo.sv
// Result FIFO: head entry is read straight from the storage array, almost-full
// is registered from the post-update occupancy.
module result_fifo #(
  parameter int DWIDTH       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DWIDTH-1:0]            push_data,
  input  logic                         pop,
  output logic [DWIDTH-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0]   count_reg, count_next;
  logic              almost_full_reg;
  logic              wr_en, rd_en;

  assign rd_en = pop & (count_reg != '0);
  // A full FIFO still accepts a push when the same cycle frees the head slot.
  assign wr_en = push & ((count_reg != CNTW'(DEPTH)) | rd_en);

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en)
      count_next = count_reg + CNTW'(1);
    else if (rd_en && !wr_en)
      count_next = count_reg - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      almost_full_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= (wr_ptr_reg == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTRW'(1);
      if (rd_en)
        rd_ptr_reg <= (rd_ptr_reg == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTRW'(1);
      count_reg       <= count_next;
      almost_full_reg <= (count_next >= CNTW'(AFULL_THRESH));
    end
  end

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CNTW'(DEPTH));
  assign almost_full = almost_full_reg;
  assign count       = count_reg;
  assign head_data   = empty ? '0 : mem[rd_ptr_reg];
endmodule

// File: rtl/dpe_accumulator.sv
// Sums consecutive DPE tile results per batch lane into saturated dot products
// and queues each completed group in the result FIFO.
module dpe_accumulator
  import npu_pkg::*;
#(
  parameter int IDATAW       = DPE_ODATAW,
  parameter int ODATAW       = 32,
  parameter int BATCH        = 1,
  parameter int MAX_TILES    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_THRESH = 6
) (
  input logic              clk,
  input logic              rst,
  dpe_accumulator_if.slave bus
);
  localparam int TILEW  = $clog2(MAX_TILES + 1);
  localparam int DWIDTH = BATCH * ODATAW;
  localparam int CNTW   = $clog2(FIFO_DEPTH + 1);

  acc_state_e                   state_reg, state_next;
  logic [BATCH-1:0][ODATAW-1:0] acc_reg, acc_next, sum;
  logic [TILEW-1:0]             cnt_reg, cnt_next, tiles_reg, tiles_next, tiles_in;
  logic                         push, pop, overflow_reg;
  logic                         fifo_full, fifo_empty, fifo_afull;
  logic [CNTW-1:0]              fifo_count;
  logic [DWIDTH-1:0]            fifo_head;

  // In IDLE the adder base is zero, so the first tile is just sign-extended.
  for (genvar gi = 0; gi < BATCH; gi++) begin : g_lane
    logic signed [IDATAW-1:0] din;
    logic        [ODATAW-1:0] base;
    assign din     = bus.i_data[gi];
    assign base    = (state_reg == ACC_ACCUM) ? acc_reg[gi] : '0;
    assign sum[gi] = ODATAW'(sat_add(SAT_W'($signed(base)), SAT_W'(din), ODATAW));
  end

  always_comb begin
    if (bus.i_num_tiles == '0)
      tiles_in = TILEW'(1);
    else if (bus.i_num_tiles > TILEW'(MAX_TILES))
      tiles_in = TILEW'(MAX_TILES);
    else
      tiles_in = bus.i_num_tiles;
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    tiles_next = tiles_reg;
    push       = 1'b0;
    if (bus.i_valid) begin
      case (state_reg)
        ACC_IDLE: begin
          tiles_next = tiles_in;
          if (tiles_in == TILEW'(1)) begin
            push     = 1'b1;
            acc_next = '0;
            cnt_next = '0;
          end else begin
            acc_next   = sum;
            cnt_next   = TILEW'(1);
            state_next = ACC_ACCUM;
          end
        end
        ACC_ACCUM: begin
          if (cnt_reg + TILEW'(1) == tiles_reg) begin
            push       = 1'b1;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = ACC_IDLE;
          end else begin
            acc_next = sum;
            cnt_next = cnt_reg + TILEW'(1);
          end
        end
        default: state_next = ACC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ACC_IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      tiles_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      tiles_reg    <= tiles_next;
      overflow_reg <= overflow_reg | (push & fifo_full & ~pop);
    end
  end

  assign pop = ~fifo_empty & bus.i_ready;

  result_fifo #(
    .DWIDTH      (DWIDTH),
    .DEPTH       (FIFO_DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (sum),
    .pop        (pop),
    .head_data  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .almost_full(fifo_afull),
    .count      (fifo_count)
  );

  assign bus.o_valid       = (fifo_count != '0);
  assign bus.o_data        = fifo_head;
  assign bus.o_almost_full = fifo_afull;
  assign bus.o_overflow    = overflow_reg;
endmodule

// File: tb/tb_dpe_accumulator.sv
// Scenario bench for dpe_accumulator: expected results queue up as groups are
// issued and are compared against the FIFO head as it is drained.
module tb_dpe_accumulator;
  import npu_pkg::*;

  localparam int IDATAW       = DPE_ODATAW;
  localparam int ODATAW       = 24;
  localparam int BATCH        = 1;
  localparam int MAX_TILES    = 16;
  localparam int FIFO_DEPTH   = 8;
  localparam int AFULL_THRESH = 6;
  localparam int TILEW        = $clog2(MAX_TILES + 1);
  localparam logic signed [ODATAW-1:0] SMAX = {1'b0, {(ODATAW-1){1'b1}}};
  localparam logic signed [ODATAW-1:0] SMIN = {1'b1, {(ODATAW-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;
  logic signed [ODATAW-1:0] exp_q[$];
  logic signed [ODATAW-1:0] exp_v;

  always #5 clk = ~clk;

  dpe_accumulator_if #(.BATCH(BATCH), .IDATAW(IDATAW), .ODATAW(ODATAW), .TILEW(TILEW)) bus ();

  dpe_accumulator #(
    .IDATAW(IDATAW), .ODATAW(ODATAW), .BATCH(BATCH), .MAX_TILES(MAX_TILES),
    .FIFO_DEPTH(FIFO_DEPTH), .AFULL_THRESH(AFULL_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int nt);
    bus.i_valid        = 1'b1;
    bus.i_data[0]      = IDATAW'(d);
    bus.i_num_tiles    = TILEW'(nt);
    cyc();
    bus.i_valid        = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_valid); else passed++;
    checks++; if (bus.o_data !== '0) $display("FAIL reset_data: got %0d expected 0", bus.o_data); else passed++;
    checks++; if (bus.o_almost_full !== 1'b0) $display("FAIL reset_afull: got %b expected 0", bus.o_almost_full); else passed++;
    checks++; if (bus.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.o_overflow); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_multi_tile();
    bus.i_ready = 1'b0;
    drive(100, 3);
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL multi_tile1_valid: got %b expected 0", bus.o_valid); else passed++;
    drive(-40, 0);
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL multi_tile2_valid: got %b expected 0", bus.o_valid); else passed++;
    exp_q.push_back(ODATAW'(100 - 40 + 7));
    drive(7, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL multi_tile_out: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL multi_tile_pop: got valid=%b expected 0", bus.o_valid); else passed++;
    $display("test_multi_tile done: 100 -40 7 -> 67");
  endtask

  task automatic test_single_tile();
    bus.i_ready = 1'b1;
    exp_q.push_back(ODATAW'(5));
    drive(5, 1);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL single_tile_a: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    exp_q.push_back(ODATAW'(-9));
    drive(-9, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL single_tile_b: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    cyc();
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL single_tile_drain: got valid=%b expected 0", bus.o_valid); else passed++;
    $display("test_single_tile done: 5 (tiles=1), -9 (tiles=0)");
  endtask

  task automatic test_saturation();
    bus.i_ready = 1'b0;
    drive(int'(SMAX), 2);
    exp_q.push_back(SMAX);
    drive(int'(SMAX), 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL sat_pos: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1; cyc(); bus.i_ready = 1'b0;
    drive(int'(SMIN), 2);
    exp_q.push_back(SMIN);
    drive(int'(SMIN), 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL sat_neg: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1; cyc(); bus.i_ready = 1'b0;
    // Saturation on every add: max + max clamps, then -1 pulls it below max.
    drive(int'(SMAX), 3);
    drive(int'(SMAX), 0);
    exp_q.push_back(SMAX - ODATAW'(1));
    drive(-1, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL sat_per_add: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1; cyc(); bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL sat_drain: got valid=%b expected 0", bus.o_valid); else passed++;
    $display("test_saturation done");
  endtask

  task automatic test_clamp_and_gap();
    int total;
    total = 0;
    bus.i_ready = 1'b0;
    for (int k = 1; k <= MAX_TILES; k++) begin
      total += k;
      if (k == MAX_TILES) exp_q.push_back(ODATAW'(total));
      drive(k, (k == 1) ? MAX_TILES + 4 : 0);
      if (k == 8) begin
        cyc();
        cyc();
      end
      if (k == MAX_TILES - 1) begin
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL clamp_early: got valid=%b expected 0", bus.o_valid); else passed++;
      end
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL clamp_out: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1; cyc(); bus.i_ready = 1'b0;
    $display("test_clamp_and_gap done: tiles=20 clamped to 16, sum=%0d", total);
  endtask

  task automatic test_overflow();
    int v;
    int occ;
    do_reset();
    bus.i_ready = 1'b0;
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) begin
      v = 1000 * k - 4321;
      if (k <= FIFO_DEPTH) exp_q.push_back(ODATAW'(v));
      drive(v, 1);
      occ = (k < FIFO_DEPTH) ? k : FIFO_DEPTH;
      checks++;
      if (bus.o_almost_full !== (occ >= AFULL_THRESH))
        $display("FAIL ovf_afull push %0d: got %b expected %b", k, bus.o_almost_full, (occ >= AFULL_THRESH));
      else passed++;
      checks++;
      if (bus.o_overflow !== (k == FIFO_DEPTH + 1))
        $display("FAIL ovf_flag push %0d: got %b expected %b", k, bus.o_overflow, (k == FIFO_DEPTH + 1));
      else passed++;
    end
    bus.i_ready = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
        $display("FAIL ovf_drain %0d: got valid=%b data=%0d expected valid=1 data=%0d", k, bus.o_valid, $signed(bus.o_data[0]), exp_v);
      else passed++;
      cyc();
    end
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL ovf_empty: got valid=%b expected 0", bus.o_valid); else passed++;
    checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.o_overflow); else passed++;
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    int v;
    do_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      v = -300 + 77 * k;
      exp_q.push_back(ODATAW'(v));
      drive(v, 1);
    end
    checks++; if (bus.o_almost_full !== 1'b1) $display("FAIL full_afull: got %b expected 1", bus.o_almost_full); else passed++;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL full_head: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1;
    exp_q.push_back(ODATAW'(555));
    drive(555, 1);
    checks++; if (bus.o_overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b expected 0", bus.o_overflow); else passed++;
    checks++; if (bus.o_almost_full !== 1'b1) $display("FAIL full_pp_afull: got %b expected 1", bus.o_almost_full); else passed++;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
        $display("FAIL full_drain %0d: got valid=%b data=%0d expected valid=1 data=%0d", k, bus.o_valid, $signed(bus.o_data[0]), exp_v);
      else passed++;
      cyc();
    end
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL full_empty: got valid=%b expected 0", bus.o_valid); else passed++;
    $display("test_full_push_pop done");
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    bus.i_ready = 1'b0;
    drive(111, 4);
    drive(222, 0);
    // Short pulse between clock edges: the partial group must vanish immediately.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", bus.o_valid); else passed++;
    drive(10, 2);
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL midrst_first: got %b expected 0", bus.o_valid); else passed++;
    exp_q.push_back(ODATAW'(10 + 20));
    drive(20, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1 || $signed(bus.o_data[0]) !== exp_v)
      $display("FAIL midrst_out: got valid=%b data=%0d expected valid=1 data=%0d", bus.o_valid, $signed(bus.o_data[0]), exp_v);
    else passed++;
    bus.i_ready = 1'b1; cyc(); bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL midrst_drain: got %b expected 0", bus.o_valid); else passed++;
    $display("test_reset_mid_group done: 10 + 20 -> 30");
  endtask

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_num_tiles = '0;
    bus.i_ready     = 1'b0;
    test_reset();
    test_multi_tile();
    test_single_tile();
    test_saturation();
    test_clamp_and_gap();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_group();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
